// File: rtl/io_hub.sv
// io_hub: LED register, synchronised switches, debounced buttons with sticky rise flags; zero-latency reads, writes at the edge, no backpressure.
// Optional registered irq on pending flags when IO_HUB_IRQ_EN is defined; otherwise irq is tied low.
module io_hub #(
   parameter int NUM_BTN   = 2,
   parameter int LED_W     = 24,
   parameter int SW_W      = 24,
   parameter int DB_CYCLES = 20000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_read,
   input  logic               io_write,
   input  logic [3:0]         addr,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   input  logic [SW_W-1:0]    switches,
   input  logic [NUM_BTN-1:0] btn,
   output logic [LED_W-1:0]   leds,
   output logic               irq
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   localparam logic [1:0] REG_LED   = 2'd0;
   localparam logic [1:0] REG_SW    = 2'd1;
   localparam logic [1:0] REG_LEVEL = 2'd2;
   localparam logic [1:0] REG_PEND  = 2'd3;

   logic [LED_W-1:0]            leds_q, leds_d;
   logic [SW_W-1:0]             sw_s1_q, sw_s2_q;
   logic [NUM_BTN-1:0]          btn_s1_q, btn_s2_q;
   logic [NUM_BTN-1:0]          stable_q, stable_d;
   logic [NUM_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [NUM_BTN-1:0]          pend_q, pend_d;
   logic [NUM_BTN-1:0]          clr;
   logic                        wr_led, wr_pend;
   logic                        unused_bits;

   assign unused_bits = ^{addr[1:0], write_data};

   assign wr_led  = io_write && (addr[3:2] == REG_LED);
   assign wr_pend = io_write && (addr[3:2] == REG_PEND);
   assign clr     = wr_pend ? write_data[NUM_BTN-1:0] : '0;
   assign leds_d  = wr_led ? write_data[LED_W-1:0] : leds_q;

   // Each button needs DB_CYCLES consecutive disagreeing samples before the level flips.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (btn_s2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = btn_s2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // A new rising level is OR-ed in after the clear so it survives a same-edge clear.
   assign pend_d = (pend_q & ~clr) | (stable_d & ~stable_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         leds_q   <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         pend_q   <= '0;
      end else begin
         leds_q   <= leds_d;
         sw_s1_q  <= switches;
         sw_s2_q  <= sw_s1_q;
         btn_s1_q <= btn;
         btn_s2_q <= btn_s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
      end
   end

   assign leds = leds_q;

   always_comb begin
      read_data = '0;
      if (io_read) begin
         case (addr[3:2])
            REG_LED:   read_data = 32'(leds_q);
            REG_SW:    read_data = 32'(sw_s2_q);
            REG_LEVEL: read_data = 32'(stable_q);
            REG_PEND:  read_data = 32'(pend_q);
            default:   read_data = '0;
         endcase
      end
   end

`ifdef IO_HUB_IRQ_EN
   logic irq_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |pend_q;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule
